// File: rtl/sync_mod_counter.sv
// sync_mod_counter: synchronous up/down modulo counter.
// clear > load > count > hold; tc is the combinational cascade carry.
module sync_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock_counter,
  input  logic             reset_counter,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_bar,
  output logic             tc,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODX = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             ov_d;
  logic             at_top;
  logic             at_bot;
  logic             at_end;
  logic             over_load;

  assign at_top    = (y_q == TOP);
  assign at_bot    = (y_q == '0);
  assign at_end    = up_down ? at_top : at_bot;
  // one extra bit so MODULUS == 2**WIDTH is representable
  assign over_load = ({1'b0, load_value} >= MODX);

  always_comb begin
    y_d  = y_q;
    ov_d = 1'b0;
    if (clear) begin
      y_d = '0;
    end else if (load) begin
      y_d = over_load ? TOP : load_value;
    end else if (enable) begin
      ov_d = at_end;
      if (at_end) begin
        if (!SATURATE) begin
          y_d = up_down ? '0 : TOP;
        end
      end else begin
        y_d = up_down ? y_q + ONE : y_q - ONE;
      end
    end
  end

  always_ff @(posedge clock_counter or posedge reset_counter) begin
    if (reset_counter) begin
      y_q      <= '0;
      overflow <= 1'b0;
    end else begin
      y_q      <= y_d;
      overflow <= ov_d;
    end
  end

  assign y     = y_q;
  assign y_bar = ~y_q;
  assign tc    = enable & at_end;

endmodule

// File: tb/tb_sync_mod_counter.sv
// tb_sync_mod_counter: directed + random checks of sync_mod_counter
// against an arithmetic reference model, plus a two-digit BCD cascade.
module tb_sync_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ud;
  logic       clr;
  logic       ld;
  logic [3:0] lv;
  logic       cen;
  logic       zero;

  logic [3:0] y_o  [3];
  logic [3:0] yb_o [3];
  logic       tc_o [3];
  logic       ov_o [3];

  logic [3:0] lo_y, lo_yb, hi_y, hi_yb;
  logic       lo_tc, lo_ov, hi_tc, hi_ov;

  int checks = 0;
  int errors = 0;

  int mods [3] = '{10, 10, 16};
  bit sats [3] = '{0, 1, 0};
  int y_m  [3];
  int ov_m [3];
  int k, lo_ov_m, hi_ov_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .clock_counter(clk), .reset_counter(rst), .enable(en),
    .up_down(ud), .clear(clr), .load(ld), .load_value(lv),
    .y(y_o[0]), .y_bar(yb_o[0]), .tc(tc_o[0]), .overflow(ov_o[0])
  );

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .clock_counter(clk), .reset_counter(rst), .enable(en),
    .up_down(ud), .clear(clr), .load(ld), .load_value(lv),
    .y(y_o[1]), .y_bar(yb_o[1]), .tc(tc_o[1]), .overflow(ov_o[1])
  );

  sync_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_bin (
    .clock_counter(clk), .reset_counter(rst), .enable(en),
    .up_down(ud), .clear(clr), .load(ld), .load_value(lv),
    .y(y_o[2]), .y_bar(yb_o[2]), .tc(tc_o[2]), .overflow(ov_o[2])
  );

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .clock_counter(clk), .reset_counter(rst), .enable(cen),
    .up_down(1'b1), .clear(zero), .load(zero), .load_value(4'd0),
    .y(lo_y), .y_bar(lo_yb), .tc(lo_tc), .overflow(lo_ov)
  );

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .clock_counter(clk), .reset_counter(rst), .enable(lo_tc),
    .up_down(1'b1), .clear(zero), .load(zero), .load_value(4'd0),
    .y(hi_y), .y_bar(hi_yb), .tc(hi_tc), .overflow(hi_ov)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: next count from plain modular / clamped arithmetic.
  function automatic void mstep(input int y, input int m, input bit sat,
                                output int ny, output int ov);
    ny = y;
    ov = 0;
    if (clr) ny = 0;
    else if (ld) ny = (int'(lv) >= m) ? m - 1 : int'(lv);
    else if (en && ud) begin
      ov = (y + 1 >= m) ? 1 : 0;
      ny = sat ? ((y + 1 > m - 1) ? m - 1 : y + 1) : (y + 1) % m;
    end else if (en) begin
      ov = (y - 1 < 0) ? 1 : 0;
      ny = sat ? ((y - 1 < 0) ? 0 : y - 1) : (y + m - 1) % m;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      y_m[i]  = 0;
      ov_m[i] = 0;
    end
    k       = 0;
    lo_ov_m = 0;
    hi_ov_m = 0;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      int etc;
      etc = (en && ((ud && y_m[i] == mods[i] - 1) ||
                    (!ud && y_m[i] == 0))) ? 1 : 0;
      chk($sformatf("%s[%0d]/y", tag, i), 32'(y_o[i]), y_m[i]);
      chk($sformatf("%s[%0d]/ybar", tag, i), 32'(yb_o[i]),
          (~y_m[i]) & 15);
      chk($sformatf("%s[%0d]/ov", tag, i), 32'(ov_o[i]), ov_m[i]);
      chk($sformatf("%s[%0d]/tc", tag, i), 32'(tc_o[i]), etc);
    end
  endtask

  task automatic check_cas(input string tag);
    chk({tag, "/lo"}, 32'(lo_y), k % 10);
    chk({tag, "/hi"}, 32'(hi_y), k / 10);
    chk({tag, "/lo_tc"}, 32'(lo_tc), (cen && k % 10 == 9) ? 1 : 0);
    chk({tag, "/lo_ov"}, 32'(lo_ov), lo_ov_m);
    chk({tag, "/hi_ov"}, 32'(hi_ov), hi_ov_m);
  endtask

  task automatic step(input string tag);
    int ny, nov;
    #1 check_all({tag, "/pre"});
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int i = 0; i < 3; i++) begin
        mstep(y_m[i], mods[i], sats[i], ny, nov);
        y_m[i]  = ny;
        ov_m[i] = nov;
      end
      if (cen) begin
        lo_ov_m = (k % 10 == 9) ? 1 : 0;
        hi_ov_m = (k == 99) ? 1 : 0;
        k       = (k + 1) % 100;
      end else begin
        lo_ov_m = 0;
        hi_ov_m = 0;
      end
    end
    #1 check_all(tag);
  endtask

  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    ud   = 1'b1;
    clr  = 1'b0;
    ld   = 1'b0;
    lv   = 4'd0;
    cen  = 1'b0;
    zero = 1'b0;
    model_reset();

    // 1. reset, then async reset mid-count at y=7
    #2 check_all("t1init");
    en = 1'b1;
    step("t1held");
    rst = 1'b0;
    for (int j = 0; j < 7; j++) step("t1cnt");
    chk("t1at7", 32'(y_o[0]), 7);
    rst = 1'b1;
    #2;
    model_reset();
    chk("t1async_y", 32'(y_o[0]), 0);
    chk("t1async_ybar", 32'(yb_o[0]), 15);
    check_all("t1async");
    step("t1hold0");
    step("t1hold1");
    rst = 1'b0;

    // 2. up wrap from 0 over 12 edges
    ud = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step("t2");
      chk("t2seq", 32'(y_o[0]), (j + 1) % 10);
      chk("t2ov", 32'(ov_o[0]), (j == 9) ? 1 : 0);
    end

    // 3. saturating down from a loaded 2
    en = 1'b0;
    ld = 1'b1;
    lv = 4'd2;
    step("t3load");
    ld = 1'b0;
    en = 1'b1;
    ud = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step("t3");
      chk("t3seq", 32'(y_o[1]), (j == 0) ? 1 : 0);
      chk("t3ov", 32'(ov_o[1]), (j >= 2) ? 1 : 0);
      chk("t3tc", 32'(tc_o[1]), (j >= 1) ? 1 : 0);
    end

    // 4. clear beats load; load clamps and ignores enable
    clr = 1'b1;
    ld  = 1'b1;
    lv  = 4'd5;
    step("t4clr");
    chk("t4clr_y", 32'(y_o[0]), 0);
    clr = 1'b0;
    en  = 1'b0;
    lv  = 4'd13;
    step("t4clamp");
    chk("t4clamp_y", 32'(y_o[0]), 9);
    chk("t4bin_y", 32'(y_o[2]), 13);
    ld = 1'b0;

    // 5. direction flip every edge from 4
    ld = 1'b1;
    lv = 4'd4;
    step("t5load");
    ld = 1'b0;
    en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      ud = (j % 2 == 0);
      step("t5");
      chk("t5seq", 32'(y_o[0]), (j % 2 == 0) ? 5 : 4);
      chk("t5ov", 32'(ov_o[0]), 0);
    end

    // 6. BCD cascade 00 -> 99 -> 00
    en  = 1'b0;
    cen = 1'b1;
    check_cas("t6start");
    for (int j = 0; j < 101; j++) begin
      step("t6");
      check_cas("t6");
    end
    chk("t6final_hi", 32'(hi_y), 0);
    cen = 1'b0;

    // 7. randomized traffic
    for (int j = 0; j < 300; j++) begin
      en  = ($urandom % 4) != 0;
      ud  = $urandom % 2;
      clr = ($urandom % 16) == 0;
      ld  = ($urandom % 10) == 0;
      lv  = 4'($urandom % 16);
      if (($urandom % 40) == 0) rst_pulse("t7rst");
      step("t7");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
